axi4lite_arbiter_2to1: RTL and testbench
========================================

// Module: axi4lite_arbiter_2to1
// PURPOSE
// Shares one AXI4-Lite slave (regblock or peripheral) between two AXI4-Lite masters.
// - One transaction (read or write) outstanding at a time, round-robin between ports.
// - Channels are passed through combinationally under a registered grant.
// - Sits between the FPGA wrapper's host-side and SoC-side masters and a shared regblock.
// PARAMETERS
// DATA_WIDTH   32  data width; must match all three connected axi4lite_intf instances
// ADDR_WIDTH   32  address width; must match all three connected axi4lite_intf instances
// PORTS
// clk          in   1          single clock; all logic on rising edge
// rst          in   1          synchronous, active-high reset
// s0           intf axi4lite_intf.slave   upstream port 0 (master 0 connects here)
// s1           intf axi4lite_intf.slave   upstream port 1 (master 1 connects here)
// m            intf axi4lite_intf.master  downstream port to the shared slave
// grant        out  1          port currently owning m (0/1); valid when busy=1
// busy         out  1          1 when state != IDLE
// BEHAVIOUR
// - Port requests: wreq[i] = s_i.AWVALID; rreq[i] = s_i.ARVALID.
// - States: IDLE, WR (AW+W), WR_RESP (B), RD_ADDR (AR), RD_DATA (R).
// - IDLE arbitration, evaluated every IDLE cycle:
//   - Port: round-robin pointer rr; the port != last-served wins if it requests, else the other.
//   - Within the winning port, write beats read unless that port's last op was a write
//     and rreq is set; i.e. per-port toggle prevents starvation.
//   - Registers grant, sets the next state to WR or RD_ADDR, and clears aw_done/w_done.
//   - No request: stays IDLE.
// - WR:
//   - m.AW* and m.W* are driven from the granted port.
//   - m.AWVALID = s_g.AWVALID & ~aw_done; m.WVALID = s_g.WVALID & ~w_done.
//   - s_g.AWREADY/WREADY mirror m.AWREADY/WREADY, gated by the same done flags.
//   - aw_done/w_done are set on the respective handshakes, in either order or in the same cycle.
//   - Moves to WR_RESP in the cycle after both are done (both handshakes may occur in one cycle).
// - WR_RESP: m.BREADY = s_g.BREADY; s_g.BVALID/BRESP = m.BVALID/BRESP.
//   - On the B handshake: go to IDLE, rr <= grant, update that port's last-op = write.
// - RD_ADDR: m.AR* from s_g; s_g.ARREADY = m.ARREADY.
//   - On the AR handshake: go to RD_DATA.
// - RD_DATA: m.RREADY = s_g.RREADY; s_g.RVALID/RDATA/RRESP = m.R*.
//   - On the R handshake: go to IDLE, rr <= grant, last-op = read.
// - Ungranted port, and all ports in IDLE:
//   - All READY outputs and BVALID/RVALID are 0.
//   - RDATA, BRESP and RRESP are 0.
// - m outputs outside their active state:
//   - Valids and readies are 0.
//   - AWADDR/WDATA/WSTRB/ARADDR are 0; AWPROT/ARPROT are 3'b000.
// - Latency:
//   - Request seen in IDLE at cycle N -> m.xVALID at N+1.
//   - Completion at cycle M -> IDLE at M+1 -> next forward at M+2.
// - Simultaneous events:
//   - Both ports requesting: rr decides. Requests arriving mid-transaction wait (valid held by the master).
//   - A port asserting both AWVALID and ARVALID: resolved by the per-port toggle.
// - No address decoding and no response generation: responses are passed through unchanged (SLVERR included).
// - Reset, including mid-transaction:
//   - Next edge forces state=IDLE, rr=1 (s0 wins first), last-op=read for both ports.
//   - aw_done=w_done=0, grant=0, busy=0; all valid/ready outputs go 0 immediately after that edge.
//   - The abandoned transaction is not completed. System reset is global, so the AXI violation is accepted.
// TESTING
// - Reset, then s0 writes 0xDEADBEEF @0x10 (WSTRB 0xF) -> m sees AW/W at N+1; s0.BVALID with BRESP=0; grant=0.
// - s0 and s1 both assert ARVALID in the same cycle after reset -> s0 served first, s1 next; s1.ARREADY=0 until then.
// - s1 presents AW at cycle 3 and W at cycle 7 -> m.AWVALID drops after its handshake; WR_RESP entered only after the W handshake.
// - s0 holds AWVALID and ARVALID continuously with s1 idle -> write, read, write alternate; no starvation across 6 transactions.
// - Slave stalls BVALID for 20 cycles while s1 requests -> s1 untouched until s0's B handshake; then s1 forwarded 2 cycles later.
// - rst asserted during RD_DATA -> next cycle busy=0 and all m/s valid and ready outputs are 0; s0 wins the first request after reset.

Source files
------------

// File: rtl/axi4lite_arbiter_2to1_if.sv
// axi4lite_intf: AXI4-Lite channel bundle with master and slave views
// Ports: none; parameters DATA_WIDTH and ADDR_WIDTH size the data and address fields.
// master modport drives AW/W/AR payloads, valids and B/R readies; slave modport is the mirror.
interface axi4lite_intf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4lite_arbiter_2to1.sv
// axi4lite_arbiter_2to1: shares one AXI4-Lite slave between two masters, one transaction at a time
// Ports:
//   clk   - clock, all logic on rising edge
//   rst   - synchronous active-high reset
//   s0/s1 - upstream slave ports for masters 0 and 1
//   m     - downstream master port to the shared slave
//   grant - port owning m, meaningful while busy
//   busy  - a transaction is in progress
module axi4lite_arbiter_2to1 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    axi4lite_intf.slave  s0,
    axi4lite_intf.slave  s1,
    axi4lite_intf.master m,
    output logic        grant,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t state, state_n;
    logic grant_n, rr, rr_n, aw_done, aw_done_n, w_done, w_done_n;
    logic [1:0] last_wr, last_wr_n, wreq, rreq;
    logic pick, pick_wr;
    logic st_wr, st_wresp, st_rdaddr, st_rddata;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [ADDR_WIDTH-1:0] g_awaddr, g_araddr;
    logic [2:0] g_awprot, g_arprot;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic [DATA_WIDTH/8-1:0] g_wstrb;
    logic g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;

    assign wreq = {s1.awvalid, s0.awvalid};
    assign rreq = {s1.arvalid, s0.arvalid};
    // rr holds the last-served port, so the other one gets first refusal
    assign pick = (wreq[~rr] | rreq[~rr]) ? ~rr : rr;
    // a port that just wrote yields to its own pending read, and vice versa
    assign pick_wr = wreq[pick] & ~(last_wr[pick] & rreq[pick]);

    assign st_wr     = state == WR;
    assign st_wresp  = state == WR_RESP;
    assign st_rdaddr = state == RD_ADDR;
    assign st_rddata = state == RD_DATA;
    assign busy      = state != IDLE;

    assign g_awaddr  = grant ? s1.awaddr  : s0.awaddr;
    assign g_awprot  = grant ? s1.awprot  : s0.awprot;
    assign g_awvalid = grant ? s1.awvalid : s0.awvalid;
    assign g_wdata   = grant ? s1.wdata   : s0.wdata;
    assign g_wstrb   = grant ? s1.wstrb   : s0.wstrb;
    assign g_wvalid  = grant ? s1.wvalid  : s0.wvalid;
    assign g_bready  = grant ? s1.bready  : s0.bready;
    assign g_araddr  = grant ? s1.araddr  : s0.araddr;
    assign g_arprot  = grant ? s1.arprot  : s0.arprot;
    assign g_arvalid = grant ? s1.arvalid : s0.arvalid;
    assign g_rready  = grant ? s1.rready  : s0.rready;

    assign m.awvalid = st_wr & g_awvalid & ~aw_done;
    assign m.awaddr  = st_wr ? g_awaddr : '0;
    assign m.awprot  = st_wr ? g_awprot : 3'b000;
    assign m.wvalid  = st_wr & g_wvalid & ~w_done;
    assign m.wdata   = st_wr ? g_wdata : '0;
    assign m.wstrb   = st_wr ? g_wstrb : '0;
    assign m.bready  = st_wresp & g_bready;
    assign m.arvalid = st_rdaddr & g_arvalid;
    assign m.araddr  = st_rdaddr ? g_araddr : '0;
    assign m.arprot  = st_rdaddr ? g_arprot : 3'b000;
    assign m.rready  = st_rddata & g_rready;

    assign s0.awready = ~grant & st_wr & m.awready & ~aw_done;
    assign s0.wready  = ~grant & st_wr & m.wready & ~w_done;
    assign s0.bvalid  = ~grant & st_wresp & m.bvalid;
    assign s0.bresp   = (~grant & st_wresp) ? m.bresp : 2'b00;
    assign s0.arready = ~grant & st_rdaddr & m.arready;
    assign s0.rvalid  = ~grant & st_rddata & m.rvalid;
    assign s0.rdata   = (~grant & st_rddata) ? m.rdata : '0;
    assign s0.rresp   = (~grant & st_rddata) ? m.rresp : 2'b00;

    assign s1.awready = grant & st_wr & m.awready & ~aw_done;
    assign s1.wready  = grant & st_wr & m.wready & ~w_done;
    assign s1.bvalid  = grant & st_wresp & m.bvalid;
    assign s1.bresp   = (grant & st_wresp) ? m.bresp : 2'b00;
    assign s1.arready = grant & st_rdaddr & m.arready;
    assign s1.rvalid  = grant & st_rddata & m.rvalid;
    assign s1.rdata   = (grant & st_rddata) ? m.rdata : '0;
    assign s1.rresp   = (grant & st_rddata) ? m.rresp : 2'b00;

    assign aw_hs = m.awvalid & m.awready;
    assign w_hs  = m.wvalid & m.wready;
    assign b_hs  = m.bvalid & m.bready;
    assign ar_hs = m.arvalid & m.arready;
    assign r_hs  = m.rvalid & m.rready;

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        rr_n      = rr;
        last_wr_n = last_wr;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        case (state)
            IDLE: if (|(wreq | rreq)) begin
                grant_n   = pick;
                state_n   = pick_wr ? WR : RD_ADDR;
                aw_done_n = 1'b0;
                w_done_n  = 1'b0;
            end
            WR: begin
                aw_done_n = aw_done | aw_hs;
                w_done_n  = w_done | w_hs;
                if (aw_done_n & w_done_n) state_n = WR_RESP;
            end
            WR_RESP: if (b_hs) begin
                state_n          = IDLE;
                rr_n             = grant;
                last_wr_n[grant] = 1'b1;
            end
            RD_ADDR: if (ar_hs) state_n = RD_DATA;
            RD_DATA: if (r_hs) begin
                state_n          = IDLE;
                rr_n             = grant;
                last_wr_n[grant] = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= 1'b0;
            rr      <= 1'b1;
            last_wr <= 2'b00;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_n;
            grant   <= grant_n;
            rr      <= rr_n;
            last_wr <= last_wr_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
        end
    end
endmodule

// File: tb/tb_axi4lite_arbiter_2to1.sv
// tb_axi4lite_arbiter_2to1: scoreboard bench for the two-master AXI4-Lite arbiter
module tb_axi4lite_arbiter_2to1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic grant, busy;
    always #5 clk = ~clk;

    axi4lite_intf #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) s0_if ();
    axi4lite_intf #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) s1_if ();
    axi4lite_intf #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m_if ();

    axi4lite_arbiter_2to1 #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .s0(s0_if.slave), .s1(s1_if.slave), .m(m_if.master),
        .grant(grant), .busy(busy)
    );

    logic [1:0] awv = '0, wv = '0, bry = '0, arv = '0, rry = '0;
    logic [31:0] awa [2] = '{32'h0, 32'h0};
    logic [31:0] wd [2]  = '{32'h0, 32'h0};
    logic [31:0] ara [2] = '{32'h0, 32'h0};
    logic [3:0] wst [2]  = '{4'hf, 4'hf};

    assign s0_if.awvalid = awv[0]; assign s0_if.awaddr = awa[0]; assign s0_if.awprot = 3'b010;
    assign s0_if.wvalid  = wv[0];  assign s0_if.wdata  = wd[0];  assign s0_if.wstrb  = wst[0];
    assign s0_if.bready  = bry[0]; assign s0_if.rready = rry[0];
    assign s0_if.arvalid = arv[0]; assign s0_if.araddr = ara[0]; assign s0_if.arprot = 3'b100;
    assign s1_if.awvalid = awv[1]; assign s1_if.awaddr = awa[1]; assign s1_if.awprot = 3'b011;
    assign s1_if.wvalid  = wv[1];  assign s1_if.wdata  = wd[1];  assign s1_if.wstrb  = wst[1];
    assign s1_if.bready  = bry[1]; assign s1_if.rready = rry[1];
    assign s1_if.arvalid = arv[1]; assign s1_if.araddr = ara[1]; assign s1_if.arprot = 3'b101;

    logic [1:0] s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0] s_bresp [2];
    logic [1:0] s_rresp [2];
    logic [31:0] s_rdata [2];
    assign s_awready = {s1_if.awready, s0_if.awready};
    assign s_wready  = {s1_if.wready,  s0_if.wready};
    assign s_bvalid  = {s1_if.bvalid,  s0_if.bvalid};
    assign s_arready = {s1_if.arready, s0_if.arready};
    assign s_rvalid  = {s1_if.rvalid,  s0_if.rvalid};
    assign s_bresp[0] = s0_if.bresp; assign s_bresp[1] = s1_if.bresp;
    assign s_rresp[0] = s0_if.rresp; assign s_rresp[1] = s1_if.rresp;
    assign s_rdata[0] = s0_if.rdata; assign s_rdata[1] = s1_if.rdata;

    logic [14:0] handshakes;
    logic [14:0] quiet;
    assign handshakes = {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready,
                         s_awready, s_wready, s_bvalid, s_arready, s_rvalid};
    assign quiet = {|handshakes, |m_if.awaddr, |m_if.awprot, |m_if.wdata, |m_if.wstrb, |m_if.araddr,
                    |m_if.arprot, |s_rdata[0], |s_rdata[1], |s_bresp[0], |s_bresp[1], |s_rresp[0],
                    |s_rresp[1], 2'b00};

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int b_delay = 0, r_delay = 0;
    int aw_hs_cyc = 0, w_hs_cyc = 0, b_hs_cyc = 0, ar_first_cyc = 0, br_first_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic        wr;
        logic        port;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } txn_t;
    txn_t exp_q [$];

    function automatic void push(input logic wr, input logic port, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb);
        txn_t t;
        t.wr = wr; t.port = port; t.addr = addr; t.data = data; t.strb = strb;
        exp_q.push_back(t);
    endfunction

    // shared slave: checks forwarded requests against the scoreboard, answers with address-derived data
    initial begin
        txn_t cur;
        bit have_cur, got_aw, got_w, b_pend, r_pend, ar_seen, br_seen;
        int bcnt, rcnt;
        logic [31:0] waddr, raddr;
        {have_cur, got_aw, got_w, b_pend, r_pend, ar_seen, br_seen} = '0;
        bcnt = 0; rcnt = 0; waddr = '0; raddr = '0; cur = '0;
        forever begin
            @(negedge clk);
            m_if.awready = !got_aw;
            m_if.wready  = !got_w;
            m_if.bvalid  = b_pend && bcnt >= b_delay;
            m_if.bresp   = (b_pend && waddr[8]) ? 2'b10 : 2'b00;
            m_if.arready = !r_pend;
            m_if.rvalid  = r_pend && rcnt >= r_delay;
            m_if.rdata   = r_pend ? raddr ^ 32'h5a5a_0000 : 32'h0;
            m_if.rresp   = (r_pend && raddr[9]) ? 2'b10 : 2'b00;
            if (b_pend) bcnt++;
            if (r_pend) rcnt++;
            #1;
            if (rst) begin
                {have_cur, got_aw, got_w, b_pend, r_pend, ar_seen, br_seen} = '0;
            end else begin
                if (m_if.arvalid && !ar_seen) begin ar_seen = 1; ar_first_cyc = cyc; end
                if (m_if.bready && !br_seen) begin br_seen = 1; br_first_cyc = cyc; end
                if (got_aw && !b_pend) check("awvalid_after_hs", m_if.awvalid, 0);
                if (!have_cur && ((m_if.awvalid && m_if.awready) || (m_if.wvalid && m_if.wready) ||
                                  (m_if.arvalid && m_if.arready))) begin
                    if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
                    else cur = exp_q.pop_front();
                    have_cur = 1;
                end
                if (m_if.awvalid && m_if.awready) begin
                    check("aw_kind", cur.wr, 1);
                    check("awaddr", m_if.awaddr, cur.addr);
                    check("awprot", m_if.awprot, {2'b01, cur.port});
                    got_aw = 1; waddr = m_if.awaddr; aw_hs_cyc = cyc;
                end
                if (m_if.wvalid && m_if.wready) begin
                    check("w_kind", cur.wr, 1);
                    check("wdata", m_if.wdata, cur.data);
                    check("wstrb", m_if.wstrb, cur.strb);
                    got_w = 1; w_hs_cyc = cyc;
                end
                if (m_if.bvalid && m_if.bready) begin
                    b_hs_cyc = cyc;
                    {b_pend, got_aw, got_w, have_cur, br_seen} = '0;
                end else if (got_aw && got_w && !b_pend) begin
                    b_pend = 1; bcnt = 0;
                end
                if (m_if.arvalid && m_if.arready) begin
                    check("ar_kind", cur.wr, 0);
                    check("araddr", m_if.araddr, cur.addr);
                    check("arprot", m_if.arprot, {2'b10, cur.port});
                    r_pend = 1; rcnt = 0; raddr = m_if.araddr;
                end
                if (m_if.rvalid && m_if.rready) {r_pend, have_cur, ar_seen} = '0;
            end
        end
    end

    // whenever the arbiter is idle nothing may be forwarded in either direction
    always begin
        @(negedge clk);
        #1;
        if (busy === 1'b0) check("idle_quiet", quiet, 0);
    end

    // callers start and end on a falling edge so back-to-back requests stay asserted through IDLE
    task automatic mwrite(input logic p, input logic [31:0] a, input logic [31:0] d, input int wdly);
        bit awd = 0, wdn = 0;
        int t = 0;
        awv[p] = 1; awa[p] = a; wd[p] = d; bry[p] = 1; wv[p] = (wdly == 0);
        while (!(awd && wdn) && t < 500) begin
            #1;
            if (awv[p] && s_awready[p]) awd = 1;
            if (wv[p] && s_wready[p]) wdn = 1;
            @(negedge clk);
            t++;
            if (awd) awv[p] = 0;
            if (wdn) wv[p] = 0; else if (t >= wdly) wv[p] = 1;
        end
        check("wr_accepted", awd && wdn, 1);
        #1;
        while (!s_bvalid[p] && t < 500) begin @(negedge clk); #1; t++; end
        check("bvalid", s_bvalid[p], 1);
        check("bresp", s_bresp[p], a[8] ? 2'b10 : 2'b00);
        @(negedge clk);
        bry[p] = 0;
    endtask

    task automatic mread(input logic p, input logic [31:0] a);
        int t = 0;
        arv[p] = 1; ara[p] = a; rry[p] = 1;
        #1;
        while (!s_arready[p] && t < 500) begin @(negedge clk); #1; t++; end
        check("arready", s_arready[p], 1);
        @(negedge clk);
        arv[p] = 0;
        #1;
        while (!s_rvalid[p] && t < 500) begin @(negedge clk); #1; t++; end
        check("rvalid", s_rvalid[p], 1);
        check("rdata", s_rdata[p], a ^ 32'h5a5a_0000);
        check("rresp", s_rresp[p], a[9] ? 2'b10 : 2'b00);
        @(negedge clk);
        rry[p] = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        @(negedge clk);

        push(1, 0, 32'h10, 32'hdead_beef, 4'hf);
        fork
            mwrite(1'b0, 32'h10, 32'hdead_beef, 0);
            begin
                #1;
                check("t1_awvalid_n", m_if.awvalid, 0);
                @(negedge clk);
                #1;
                check("t1_awvalid_n1", m_if.awvalid, 1);
                check("t1_wvalid_n1", m_if.wvalid, 1);
                check("t1_grant", grant, 0);
                check("t1_busy", busy, 1);
            end
        join

        do_reset();
        push(0, 0, 32'h20, 32'h0, 4'h0);
        push(0, 1, 32'h220, 32'h0, 4'h0);
        fork
            mread(1'b0, 32'h20);
            mread(1'b1, 32'h220);
            begin
                @(negedge clk);
                #1;
                check("t2_grant", grant, 0);
                check("t2_s1_arready", s_arready[1], 0);
            end
        join

        wst[1] = 4'h3;
        push(1, 1, 32'h104, 32'h1234_5678, 4'h3);
        mwrite(1'b1, 32'h104, 32'h1234_5678, 4);
        check("t3_w_after_aw", w_hs_cyc - aw_hs_cyc, 3);
        check("t3_resp_after_w", br_first_cyc - w_hs_cyc, 1);

        for (int i = 0; i < 3; i++) begin
            push(1, 0, 32'h40 + 32'(i * 4), 32'ha000_0000 + 32'(i), 4'hf);
            push(0, 0, 32'h80 + 32'(i * 4), 32'h0, 4'h0);
        end
        fork
            for (int i = 0; i < 3; i++) mwrite(1'b0, 32'h40 + 32'(i * 4), 32'ha000_0000 + 32'(i), 0);
            for (int i = 0; i < 3; i++) mread(1'b0, 32'h80 + 32'(i * 4));
        join
        check("t4_sb_drained", exp_q.size(), 0);

        b_delay = 20;
        push(1, 0, 32'h130, 32'h5555_aaaa, 4'hf);
        push(0, 1, 32'h234, 32'h0, 4'h0);
        fork
            mwrite(1'b0, 32'h130, 32'h5555_aaaa, 0);
            begin repeat (2) @(negedge clk); mread(1'b1, 32'h234); end
        join
        b_delay = 0;
        check("t5_gap", ar_first_cyc - b_hs_cyc, 2);

        push(0, 0, 32'h50, 32'h0, 4'h0);
        mread(1'b0, 32'h50);
        r_delay = 1000;
        push(0, 0, 32'h60, 32'h0, 4'h0);
        arv[0] = 1; ara[0] = 32'h60; rry[0] = 1;
        t = 0;
        #1;
        while (!s_arready[0] && t < 50) begin @(negedge clk); #1; t++; end
        check("t6_ar_accept", s_arready[0], 1);
        @(negedge clk);
        arv[0] = 0;
        #1;
        check("t6_in_rd_data", m_if.rready, 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_handshakes", handshakes, 0);
        rry[0] = 0;
        r_delay = 0;
        @(negedge clk);
        push(0, 0, 32'h70, 32'h0, 4'h0);
        push(0, 1, 32'h270, 32'h0, 4'h0);
        fork
            mread(1'b0, 32'h70);
            mread(1'b1, 32'h270);
        join
        repeat (3) @(negedge clk);
        check("sb_leftover", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: no summary by time %0t, %0d of %0d checks failed", $time, n_fail, n_tests);
        $fatal(1);
    end
endmodule
